// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that adds BITS_PER_CYCLE bits per clock
// through a registered carry, with valid/ready handshakes on both sides.
// Optional feature macro: SERIAL_ADDER_SUB_EN (enables a-b via the sub input).
module serial_adder #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1) begin : g_bad_width
    $error("serial_adder: WIDTH must be >= 1");
  end
  if (BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic                  carry_q, carry_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]      sum_q, sum_d;
  logic                  cout_q, cout_d;

  // Operand B and initial carry as loaded on accept.
  logic [WIDTH-1:0]      op_b;
  logic                  op_cin;

  // Per-step slice adder result and the accumulator after shifting it in.
  logic [BITS_PER_CYCLE:0] step_res;
  logic [WIDTH-1:0]        acc_shift;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1: invert B and seed the carry with one.
  always_comb begin
    op_b   = sub ? ~b : b;
    op_cin = sub;
  end
`else
  // Add-only build: sub has no effect on the datapath.
  logic unused_sub;
  assign unused_sub = sub;

  // B passes straight through and the carry always starts clear.
  always_comb begin
    op_b   = b;
    op_cin = 1'b0;
  end
`endif

  // Slice adder over the low bits of the operand shift registers.
  always_comb begin
    step_res  = {1'b0, a_q[BITS_PER_CYCLE-1:0]}
              + {1'b0, b_q[BITS_PER_CYCLE-1:0]}
              + {{BITS_PER_CYCLE{1'b0}}, carry_q};
    // New result bits enter at the top; the concatenation keeps this valid
    // even when a single step covers the whole word.
    acc_shift = WIDTH'({step_res[BITS_PER_CYCLE-1:0], acc_q} >> BITS_PER_CYCLE);
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op_b;
          carry_d = op_cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        carry_d = step_res[BITS_PER_CYCLE];
        acc_d   = acc_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          // Publish only the finished word so sum never shows partials.
          sum_d   = acc_shift;
          cout_d  = step_res[BITS_PER_CYCLE];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset that discards any partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
